// File: rtl/rtc_pkg.sv
// Shared RTC definitions: FSM state encoding, default transfer
// length and RTC register address map.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } rtc_state_e;

    localparam int RTC_XFER_CYC = 44;

    localparam logic [7:0] RTC_ADDR_SEC   = 8'h20;
    localparam logic [7:0] RTC_ADDR_MIN   = 8'h21;
    localparam logic [7:0] RTC_ADDR_HOUR  = 8'h22;
    localparam logic [7:0] RTC_ADDR_DATE  = 8'h23;
    localparam logic [7:0] RTC_ADDR_MONTH = 8'h24;
    localparam logic [7:0] RTC_ADDR_YEAR  = 8'h25;
    localparam logic [7:0] RTC_ADDR_CMD   = 8'h2F;

endpackage

// File: rtl/rtc_xfer_ctrl.sv
// RTC transfer controller: sequences one bus transfer per request.
// Define RTC_BURST_EN for multi-register bursts (burst_len / last).
module rtc_xfer_ctrl
    import rtc_pkg::*;
#(
    parameter int XFER_CYC = RTC_XFER_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       wr_nrd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
`ifdef RTC_BURST_EN
    input  logic [2:0] burst_len,
    output logic       last,
`endif
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       do_it,
    output logic       w_r,
    input  logic       send_add,
    input  logic       send_data,
    input  logic       read_data,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam int CW = $clog2(XFER_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(XFER_CYC - 1);

    rtc_state_e    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    cap_q, cap_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          seen_q, seen_d;
`ifdef RTC_BURST_EN
    logic [2:0]    rem_q, rem_d;
`endif

    // State and datapath registers; reset aborts any transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            cap_q   <= 8'h00;
            rdata_q <= 8'h00;
            seen_q  <= 1'b0;
`ifdef RTC_BURST_EN
            rem_q   <= 3'd0;
`endif
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            seen_q  <= seen_d;
`ifdef RTC_BURST_EN
            rem_q   <= rem_d;
`endif
        end
    end

    // Next-state: accept, issue, count bus cycles, complete
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        seen_d  = seen_q;
`ifdef RTC_BURST_EN
        rem_d   = rem_q;
`endif
        unique case (st_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = wr_nrd;
                    addr_d  = addr;
                    wdata_d = wdata;
`ifdef RTC_BURST_EN
                    rem_d   = burst_len;
`endif
                    st_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d  = '0;
                seen_d = 1'b0;
                st_d   = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (!wr_q && read_data) begin
                    cap_d  = ad_in;
                    seen_d = 1'b1;
                end
                if (wr_q && send_data) begin
                    seen_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    st_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!wr_q) begin
                    rdata_d = cap_q;
                end
                st_d = ST_IDLE;
`ifdef RTC_BURST_EN
                if (rem_q != 3'd0) begin
                    rem_d  = rem_q - 3'd1;
                    addr_d = addr_q + 8'd1;
                    st_d   = ST_ISSUE;
                end
`endif
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; AD bus mux follows phase flags
    always_comb begin
        busy   = (st_q != ST_IDLE);
        do_it  = (st_q == ST_ISSUE);
        done   = (st_q == ST_DONE);
        err    = done && !seen_q;
        w_r    = busy && wr_q;
        ad_oe  = ((st_q == ST_ISSUE) || (st_q == ST_RUN))
                 && (send_add || (send_data && wr_q));
        ad_out = send_add ? addr_q : wdata_q;
        rdata  = (done && !wr_q) ? cap_q : rdata_q;
`ifdef RTC_BURST_EN
        last   = done && (rem_q == 3'd0);
`endif
    end

endmodule

// File: tb/tb_rtc_xfer_ctrl.sv
// Bench for rtc_xfer_ctrl: transfer table, reset abort, random run.
// Build with RTC_BURST_EN to also exercise bursts.
module tb_rtc_xfer_ctrl;

    localparam int X = 44;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       wr_nrd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] burst_len;
    logic       busy, done, err, do_it, w_r, ad_oe;
    logic [7:0] rdata, ad_out;
    logic       send_add, send_data, read_data;
    logic [7:0] ad_in;
`ifdef RTC_BURST_EN
    logic       last;
`endif

    rtc_xfer_ctrl #(.XFER_CYC(X)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .wr_nrd(wr_nrd),
        .addr(addr),
        .wdata(wdata),
`ifdef RTC_BURST_EN
        .burst_len(burst_len),
        .last(last),
`endif
        .busy(busy),
        .done(done),
        .err(err),
        .rdata(rdata),
        .do_it(do_it),
        .w_r(w_r),
        .send_add(send_add),
        .send_data(send_data),
        .read_data(read_data),
        .ad_out(ad_out),
        .ad_oe(ad_oe),
        .ad_in(ad_in)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // transaction-level reference
    bit         m_act;
    int         m_p;
    bit         m_dir;
    logic [7:0] m_addr, m_wdata, m_cap, m_rdata;
    bit         m_seen;
    int         m_rem;

    int         cyc;
    int         fmode;
    logic [7:0] f_adval;
    int         n_doit, n_done, n_last;
    int         obs_doit, obs_done;
    logic       obs_err;
    logic [7:0] obs_rdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_act = 0; m_p = 0; m_dir = 0; m_seen = 0; m_rem = 0;
        m_addr = 8'h00; m_wdata = 8'h00;
        m_cap = 8'h00; m_rdata = 8'h00;
    endtask

    // emulates the external bus-timing FSM
    task automatic drive_flags();
        bit s;
        ad_in = 8'($urandom);
        if (!m_act || fmode == 2) begin
            send_add  = ($urandom_range(0, 3) == 0);
            send_data = ($urandom_range(0, 3) == 0);
            read_data = ($urandom_range(0, 3) == 0);
        end else if (fmode == 1) begin
            send_add = 0; send_data = 0; read_data = 0;
        end else begin
            s = (m_p >= 20 && m_p <= 29);
            send_add  = (m_p >= 2 && m_p <= 6);
            send_data = s && m_dir;
            read_data = s && !m_dir;
            if (m_p == 29) ad_in = f_adval;
        end
    endtask

    task automatic check_outputs();
        bit e_done;
        e_done = m_act && (m_p == X + 1);
        chk("busy",  32'(busy),  32'(m_act));
        chk("do_it", 32'(do_it), 32'(m_act && m_p == 0));
        chk("done",  32'(done),  32'(e_done));
        chk("err",   32'(err),   32'(e_done && !m_seen));
        chk("w_r",   32'(w_r),   32'(m_act && m_dir));
        chk("ad_oe", 32'(ad_oe),
            32'(m_act && m_p <= X &&
                (send_add || (send_data && m_dir))));
        chk("ad_out", 32'(ad_out),
            32'(send_add ? m_addr : m_wdata));
        chk("rdata", 32'(rdata),
            32'((e_done && !m_dir) ? m_cap : m_rdata));
`ifdef RTC_BURST_EN
        chk("last", 32'(last), 32'(e_done && m_rem == 0));
        if (last === 1'b1) n_last++;
`endif
        if (do_it === 1'b1) begin
            n_doit++; obs_doit = cyc;
        end
        if (done === 1'b1) begin
            n_done++; obs_done = cyc;
            obs_err = err; obs_rdata = rdata;
        end
    endtask

    task automatic model_edge();
        if (m_act) begin
            if (m_p >= 1 && m_p <= X) begin
                if (!m_dir && read_data) begin
                    m_cap = ad_in; m_seen = 1;
                end
                if (m_dir && send_data) m_seen = 1;
            end
            if (m_p == X + 1) begin
                if (!m_dir) m_rdata = m_cap;
                if (m_rem > 0) begin
                    m_rem--; m_addr = m_addr + 8'd1;
                    m_p = 0; m_seen = 0;
                end else begin
                    m_act = 0;
                end
            end else begin
                m_p++;
            end
        end else if (req) begin
            m_act = 1; m_p = 0; m_seen = 0;
            m_dir = wr_nrd; m_addr = addr; m_wdata = wdata;
`ifdef RTC_BURST_EN
            m_rem = int'(burst_len);
`else
            m_rem = 0;
`endif
        end
    endtask

    // one clock: inputs already set just after posedge
    task automatic cyc_step();
        drive_flags();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (!reset) model_edge();
        cyc++;
        #1;
    endtask

    task automatic run_xfer(input bit w, input logic [7:0] a,
                            input logic [7:0] d, input int fm,
                            input logic [7:0] av, input bit nz,
                            input logic [2:0] bl);
        int guard;
        fmode = fm; f_adval = av;
        n_doit = 0; n_done = 0; n_last = 0;
        req = 1; wr_nrd = w; addr = a; wdata = d; burst_len = bl;
        cyc_step();
        guard = 0;
        while (m_act && guard < 400) begin
            req = nz ? 1'($urandom) : 1'b0;
            if (nz) begin
                wr_nrd = 1'($urandom);
                addr = 8'($urandom);
                wdata = 8'($urandom);
                burst_len = 3'($urandom);
            end
            cyc_step();
            guard++;
        end
        req = 0; burst_len = 3'd0;
        chk("xfer_timeout", 32'(guard < 400), 32'd1);
        chk("done_count", 32'(n_done), 32'(bl) + 32'd1);
        chk("doit_count", 32'(n_doit), 32'(bl) + 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_err"},    32'(err),    32'd0);
        chk({tag, "_do_it"},  32'(do_it),  32'd0);
        chk({tag, "_w_r"},    32'(w_r),    32'd0);
        chk({tag, "_ad_oe"},  32'(ad_oe),  32'd0);
        chk({tag, "_rdata"},  32'(rdata),  32'd0);
        chk({tag, "_ad_out"}, 32'(ad_out), 32'd0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] adval;
        int         fmode;
        bit         noise;
        bit         exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vt[7];

    initial begin
        int guard;
        vt[0] = '{0, 8'h21, 8'h00, 8'h59, 0, 0, 0, 8'h59};
        vt[1] = '{1, 8'h22, 8'h13, 8'h00, 0, 0, 0, 8'h59};
        vt[2] = '{0, 8'h20, 8'h00, 8'h00, 1, 0, 1, 8'h59};
        vt[3] = '{1, 8'h23, 8'h44, 8'h00, 1, 0, 1, 8'h59};
        vt[4] = '{0, 8'h24, 8'h00, 8'hA5, 0, 1, 0, 8'hA5};
        vt[5] = '{1, 8'h2F, 8'h80, 8'h00, 0, 1, 0, 8'hA5};
        vt[6] = '{0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 8'h00};

        cyc = 0; fmode = 2; f_adval = 8'h00;
        n_doit = 0; n_done = 0; n_last = 0;
        obs_doit = 0; obs_done = 0;
        obs_err = 0; obs_rdata = 8'h00;
        reset = 1; req = 0; wr_nrd = 0;
        addr = 8'h00; wdata = 8'h00; burst_len = 3'd0;
        send_add = 0; send_data = 0; read_data = 0; ad_in = 8'h00;
        model_clear();
        @(posedge clk); #1;
        chk_all_zero("rst");
        cyc_step();
        reset = 0;
        cyc_step();

        for (int i = 0; i < 7; i++) begin
            run_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].fmode,
                     vt[i].adval, vt[i].noise, 3'd0);
            chk($sformatf("v%0d_latency", i),
                32'(obs_done - obs_doit), 32'(X + 1));
            chk($sformatf("v%0d_err", i),
                32'(obs_err), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_rdata", i),
                32'(obs_rdata), 32'(vt[i].exp_rdata));
            n_doit = 0;
            for (int k = 0; k < 3; k++) cyc_step();
            chk($sformatf("v%0d_no_doit", i), 32'(n_doit), 32'd0);
        end

        // reset while the RUN counter is at 20
        fmode = 0; f_adval = 8'h66;
        req = 1; wr_nrd = 0; addr = 8'h25; wdata = 8'h00;
        cyc_step();
        req = 0;
        guard = 0;
        while (m_p < 21 && guard < 100) begin
            cyc_step(); guard++;
        end
        chk("abort_reach", 32'(m_p), 32'd21);
        reset = 1;
        #1;
        chk_all_zero("abort");
        model_clear();
        cyc_step();
        reset = 0;
        n_done = 0; n_doit = 0;
        for (int k = 0; k < 60; k++) cyc_step();
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_xfer(0, 8'h21, 8'h00, 0, 8'h31, 0, 3'd0);
        chk("post_abort_rdata", 32'(obs_rdata), 32'h31);
        chk("post_abort_err", 32'(obs_err), 32'd0);

`ifdef RTC_BURST_EN
        run_xfer(0, 8'hFE, 8'h00, 0, 8'h3C, 0, 3'd2);
        chk("burst_last_cnt", 32'(n_last), 32'd1);
        chk("burst_addr_wrap", 32'(m_addr), 32'h00);
`endif

        for (int t = 0; t < 40; t++) begin
            int g, r, fm;
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                req = 0; cyc_step();
            end
            r = $urandom_range(0, 9);
            fm = (r < 5) ? 2 : ((r < 8) ? 0 : 1);
`ifdef RTC_BURST_EN
            run_xfer(1'($urandom), 8'($urandom), 8'($urandom), fm,
                     8'($urandom), 1'($urandom),
                     3'($urandom_range(0, 2)));
`else
            run_xfer(1'($urandom), 8'($urandom), 8'($urandom), fm,
                     8'($urandom), 1'($urandom), 3'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
